// File: rtl/noc_input_port.sv
// Router input stage: small flit FIFO plus XY route computation on each head flit.
// Holds a stable output-port request for the whole packet, then streams its flits.
module noc_input_port #(
    parameter int FLIT_W       = 16,
    parameter int COORD_W      = 2,
    parameter int CUR_X        = 1,
    parameter int CUR_Y        = 1,
    parameter int DEPTH        = 4,
    parameter int SETUP_CYCLES = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [2:0]        request,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(SETUP_CYCLES + 1);

    localparam logic [PTR_W:0]         FULL_CNT   = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]       SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [COORD_W-1:0]     CUR_X_C    = COORD_W'(CUR_X);
    localparam logic [COORD_W-1:0]     CUR_Y_C    = COORD_W'(CUR_Y);

    localparam logic [2:0] REQ_L    = 3'd0;
    localparam logic [2:0] REQ_E    = 3'd1;
    localparam logic [2:0] REQ_W    = 3'd2;
    localparam logic [2:0] REQ_N    = 3'd3;
    localparam logic [2:0] REQ_S    = 3'd4;
    localparam logic [2:0] REQ_NONE = 3'd7;

    // ROUTE is the cycle in which the head's route is computed and registered.
    typedef enum logic [1:0] {IDLE, ROUTE, SETUP, ACTIVE} state_e;

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              push, pop, fifo_empty;
    logic [FLIT_W-1:0] head_flit;
    logic [1:0]        head_type;
    logic [COORD_W-1:0] dest_x, dest_y;
    logic [2:0]        route;

    state_e            state_q, state_d;
    logic [2:0]        req_q, req_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign fifo_empty = (count_q == '0);
    assign in_ready   = (count_q != FULL_CNT);
    assign push       = in_valid && in_ready;
    // Stray non-head flits are discarded through the same read port.
    assign pop        = (state_q == ACTIVE && out_valid && out_ready) || err_drop;
    assign head_flit  = mem_q[rd_ptr_q];
    assign head_type  = head_flit[FLIT_W-1 -: 2];
    assign dest_x     = head_flit[FLIT_W-3 -: COORD_W];
    assign dest_y     = head_flit[FLIT_W-3-COORD_W -: COORD_W];
    assign request    = req_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; occupancy is tracked by count_q and out_flit is gated.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_flit;
    end

    // XY routing: X resolved first, unsigned compares, Y grows northward.
    always_comb begin
        // NOTE: default first so no path leaves the variable unassigned (no latch).
        route = REQ_L;
        if (dest_x > CUR_X_C)      route = REQ_E;
        else if (dest_x < CUR_X_C) route = REQ_W;
        else if (dest_y > CUR_Y_C) route = REQ_N;
        else if (dest_y < CUR_Y_C) route = REQ_S;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= REQ_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && head_type[0]) state_d = ROUTE;
            end
            ROUTE: begin
                req_d   = route;
                cnt_d   = '0;
                state_d = SETUP;
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) state_d = ACTIVE;
                else                     cnt_d   = cnt_q + 1'b1;
            end
            ACTIVE: begin
                if (pop && head_type[1]) begin
                    state_d = IDLE;
                    req_d   = REQ_NONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == ACTIVE) && !fifo_empty;
        out_flit  = out_valid ? head_flit : '0;
        err_drop  = (state_q == IDLE) && !fifo_empty && !head_type[0];
    end

endmodule
